// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4x4 multiplier between NUM_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [4*NUM_REQ-1:0]   REQ_A,
    input  logic [4*NUM_REQ-1:0]   REQ_B,
    output logic [NUM_REQ-1:0]     GNT,
    output logic [NUM_REQ-1:0]     RSP_VALID,
    output logic [7:0]             RSP_Y,
    output logic                   RSP_ERR,
    output logic                   BUSY,
    output logic [3:0]             MULT_A,
    output logic [3:0]             MULT_B,
    output logic                   MULT_START,
    input  logic                   MULT_DONE,
    input  logic [7:0]             MULT_Y
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]           rsp_y_q, rsp_y_d;
    logic                 busy_q, busy_d;
    logic [3:0]           mult_a_q, mult_a_d;
    logic [3:0]           mult_b_q, mult_b_d;
    logic                 mult_start_q, mult_start_d;
`ifdef MULT_ARB_TIMEOUT_EN
    logic [7:0]           cnt_q, cnt_d;
    logic                 rsp_err_q, rsp_err_d;
`endif

    logic [3:0]           op_a [NUM_REQ];
    logic [3:0]           op_b [NUM_REQ];
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign op_a[g] = REQ_A[4*g +: 4];
        assign op_b[g] = REQ_B[4*g +: 4];
    end

    // Search starts just past the last served requester, so it ends up lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        rsp_valid_d  = '0;
        rsp_y_d      = rsp_y_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        mult_start_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = ISSUE;
                    idx_d        = win;
                    gnt_d        = NUM_REQ'(1) << win;
                    mult_a_d     = op_a[win];
                    mult_b_d     = op_b[win];
                    mult_start_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_DONE: begin
                if (MULT_DONE) begin
                    state_d     = RESPOND;
                    rsp_y_d     = MULT_Y;
                    rsp_valid_d = gnt_q;
`ifdef MULT_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                    state_d     = RESPOND;
                    rsp_y_d     = '0;
                    rsp_valid_d = gnt_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 8'd1;
`endif
                end
            end
            RESPOND: begin
                state_d = IDLE;
                last_d  = idx_q;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_y_q      <= '0;
            busy_q       <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_start_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_y_q      <= rsp_y_d;
            busy_q       <= busy_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_start_q <= mult_start_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    assign RSP_ERR = rsp_err_q;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign RSP_ERR        = 1'b0;
`endif

    assign GNT        = gnt_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_Y      = rsp_y_q;
    assign BUSY       = busy_q;
    assign MULT_A     = mult_a_q;
    assign MULT_B     = mult_b_q;
    assign MULT_START = mult_start_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NUM_REQ=2); the multiplier is driven by hand.
// Timeout steps run only when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_share_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] REQ;
    logic [7:0] REQ_A, REQ_B;
    logic [1:0] GNT, RSP_VALID;
    logic [7:0] RSP_Y;
    logic       RSP_ERR, BUSY;
    logic [3:0] MULT_A, MULT_B;
    logic       MULT_START, MULT_DONE;
    logic [7:0] MULT_Y;

    int checks = 0;
    int errors = 0;

    mult_share_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_Y(RSP_Y), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
        .MULT_A(MULT_A), .MULT_B(MULT_B), .MULT_START(MULT_START),
        .MULT_DONE(MULT_DONE), .MULT_Y(MULT_Y)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting from IDLE; operands are scrambled while granted
    // to confirm MULT_A/B stay latched. DONE is raised after `delay` WAIT_DONE cycles.
    task automatic serve(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] y, input int delay, input logic [1:0] req_after);
        logic [1:0] oh;
        logic [7:0] sa, sb;
        oh = 2'b01 << idx;
        step();
        check("gnt_issue", GNT, oh);
        check("start_issue", MULT_START, 1'b1);
        check("mult_a_issue", MULT_A, a);
        check("mult_b_issue", MULT_B, b);
        check("busy_issue", BUSY, 1'b1);
        check("valid_issue", RSP_VALID, 2'b00);
        REQ       = req_after;
        sa        = REQ_A;
        sb        = REQ_B;
        REQ_A     = ~sa;
        REQ_B     = ~sb;
        MULT_Y    = y;
        MULT_DONE = (delay == 0);
        step();
        check("start_drop", MULT_START, 1'b0);
        check("gnt_wait", GNT, oh);
        check("valid_wait", RSP_VALID, 2'b00);
        for (int d = 0; d < delay; d++) begin
            step();
            check("gnt_hold", GNT, oh);
            check("mult_a_hold", MULT_A, a);
            check("mult_b_hold", MULT_B, b);
            check("start_low", MULT_START, 1'b0);
            check("valid_low", RSP_VALID, 2'b00);
        end
        MULT_DONE = 1'b1;
        REQ_A     = sa;
        REQ_B     = sb;
        step();
        check("rsp_valid", RSP_VALID, oh);
        check("rsp_y", RSP_Y, y);
        check("rsp_err", RSP_ERR, 1'b0);
        check("gnt_respond", GNT, oh);
        check("busy_respond", BUSY, 1'b1);
        MULT_DONE = 1'b0;
        step();
        check("valid_clear", RSP_VALID, 2'b00);
        check("gnt_clear", GNT, 2'b00);
        check("busy_idle", BUSY, 1'b0);
        check("rsp_y_hold", RSP_Y, y);
    endtask

    initial begin
        RESET = 1'b0; REQ = 2'b00; REQ_A = '0; REQ_B = '0;
        MULT_DONE = 1'b0; MULT_Y = '0;
        step();
        step();
        check("rst_gnt", GNT, 2'b00);
        check("rst_valid", RSP_VALID, 2'b00);
        check("rst_y", RSP_Y, 8'd0);
        check("rst_err", RSP_ERR, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_a", MULT_A, 4'd0);
        check("rst_b", MULT_B, 4'd0);
        check("rst_start", MULT_START, 1'b0);

        // Single request from requester 0: 3*5 = 15, DONE one cycle after start.
        RESET = 1'b1; REQ = 2'b01; REQ_A = {4'd0, 4'd3}; REQ_B = {4'd0, 4'd5};
        serve(0, 4'd3, 4'd5, 8'd15, 0, 2'b00);

        // Fresh reset, then both requesting: rotation 0,1,0,1.
        RESET = 1'b0;
        step();
        RESET = 1'b1; REQ = 2'b11; REQ_A = {4'd15, 4'd2}; REQ_B = {4'd15, 4'd7};
        serve(0, 4'd2, 4'd7, 8'd14, 0, 2'b11);
        serve(1, 4'd15, 4'd15, 8'd225, 0, 2'b11);
        serve(0, 4'd2, 4'd7, 8'd14, 0, 2'b11);
        serve(1, 4'd15, 4'd15, 8'd225, 0, 2'b00);

        // Slow multiplier: DONE after 10 WAIT_DONE cycles; 4*6 = 24.
        REQ = 2'b01; REQ_A = {4'd3, 4'd4}; REQ_B = {4'd3, 4'd6};
        serve(0, 4'd4, 4'd6, 8'd24, 10, 2'b00);

        // Requester 1 drops REQ while waiting; it still gets its response and becomes last.
        REQ = 2'b10;
        serve(1, 4'd3, 4'd3, 8'd9, 2, 2'b00);
        REQ = 2'b11;
        serve(0, 4'd4, 4'd6, 8'd24, 0, 2'b00);

        // Reset during WAIT_DONE aborts without a response and restores requester 0 priority.
        REQ = 2'b10;
        step();
        check("abort_gnt_issue", GNT, 2'b10);
        REQ = 2'b00;
        step();
        RESET = 1'b0; MULT_DONE = 1'b1; MULT_Y = 8'd9;
        step();
        check("abort_gnt", GNT, 2'b00);
        check("abort_valid", RSP_VALID, 2'b00);
        check("abort_busy", BUSY, 1'b0);
        check("abort_y", RSP_Y, 8'd0);
        check("abort_start", MULT_START, 1'b0);
        check("abort_a", MULT_A, 4'd0);
        check("abort_b", MULT_B, 4'd0);
        RESET = 1'b1; MULT_DONE = 1'b0; REQ = 2'b11;
        serve(0, 4'd4, 4'd6, 8'd24, 0, 2'b00);

`ifdef MULT_ARB_TIMEOUT_EN
        // DONE never arrives: timeout on the 4th WAIT_DONE cycle.
        REQ = 2'b01;
        step();
        check("to_start", MULT_START, 1'b1);
        REQ = 2'b00;
        step();
        for (int d = 0; d < 3; d++) begin
            step();
            check("to_valid_low", RSP_VALID, 2'b00);
        end
        step();
        check("to_valid", RSP_VALID, 2'b01);
        check("to_err", RSP_ERR, 1'b1);
        check("to_y", RSP_Y, 8'd0);
        step();
        check("to_busy_idle", BUSY, 1'b0);

        // DONE on the same edge as the timeout: DONE wins.
        REQ = 2'b01;
        step();
        REQ = 2'b00; MULT_Y = 8'd24;
        step();
        for (int d = 0; d < 3; d++) begin
            step();
            check("race_valid_low", RSP_VALID, 2'b00);
        end
        MULT_DONE = 1'b1;
        step();
        check("race_valid", RSP_VALID, 2'b01);
        check("race_err", RSP_ERR, 1'b0);
        check("race_y", RSP_Y, 8'd24);
        MULT_DONE = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
